// File: rtl/imem_readback.sv
// Instruction-memory readback engine: walks a word range and streams each word out over valid/ready.
// Define IMEM_READBACK_CHECKSUM_EN to build the running checksum; otherwise checksum is tied to zero.
module imem_readback #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_rd_en,
  output logic [31:0]       mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [WORD_W-1:0] dump_data,
  output logic [31:0]       dump_addr,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic              xfer_c;
  logic              start_c;

  assign xfer_c  = (state == S_PRESENT) && dump_valid && dump_ready;
  assign start_c = (state == S_IDLE) && start;

  // Sequencer: every output is registered, so each transition sets the outputs for the state it enters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      dump_addr   <= '0;
      dump_last   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count != '0) begin
              addr        <= base_addr & WORD_MASK;
              remaining   <= word_count;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= base_addr & WORD_MASK;
              state       <= S_REQ;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_REQ: begin
          state <= S_WAIT;
        end

        // Memory returns data the cycle after the strobe; capture it with its address.
        S_WAIT: begin
          dump_data  <= mem_rd_data;
          dump_addr  <= addr;
          dump_last  <= (remaining == CNT_W'(1));
          dump_valid <= 1'b1;
          state      <= S_PRESENT;
        end

        S_PRESENT: begin
          if (xfer_c) begin
            dump_valid <= 1'b0;
            addr       <= addr + WORD_STEP;
            remaining  <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= addr + WORD_STEP;
              state       <= S_REQ;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy       <= 1'b0;
          dump_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_READBACK_CHECKSUM_EN
  // Running sum of accepted words; cleared by each accepted start, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum <= '0;
    end else if (start_c) begin
      checksum <= '0;
    end else if (xfer_c) begin
      checksum <= checksum + 32'(dump_data);
    end
  end
`else
  logic unused_c;
  assign unused_c = start_c;
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_readback.sv
// Directed bench for imem_readback with a one-cycle-latency instruction memory model.
module tb_imem_readback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'h0;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [31:0] dump_addr;
  logic        dump_last;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;
  int rd_total = 0;
  int rd0;

`ifdef IMEM_READBACK_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  imem_readback #(.WORD_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_addr(dump_addr), .dump_last(dump_last), .busy(busy), .done(done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:          return 32'h0002_0820;
      32'd12:         return 32'hAC09_000C;
      32'd16:         return 32'h8C0C_000C;
      32'd20:         return 32'h2022_0008;
      32'd24:         return 32'h1000_FFFF;
      32'hFFFF_FFFC:  return 32'h1234_5678;
      default:        return 32'hBAD0_0000 ^ a;
    endcase
  endfunction

  // Synchronous-read memory plus a strobe counter.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem_word(mem_rd_addr);
      rd_total    <= rd_total + 1;
    end else begin
      mem_rd_data <= 32'hBAD0_BAD0;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"},   64'(mem_rd_en),   64'd0);
    chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_valid"},   64'(dump_valid),  64'd0);
    chk({tag, "_data"},    64'(dump_data),   64'd0);
    chk({tag, "_daddr"},   64'(dump_addr),   64'd0);
    chk({tag, "_last"},    64'(dump_last),   64'd0);
    chk({tag, "_busy"},    64'(busy),        64'd0);
    chk({tag, "_done"},    64'(done),        64'd0);
    chk({tag, "_cksum"},   64'(checksum),    64'd0);
  endtask

  initial begin
    // Reset with start asserted: start must be ignored.
    rst = 1'b0; start = 1'b1; base_addr = 32'd0; word_count = 16'd1; dump_ready = 1'b1;
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b1; start = 1'b0;
    step();
    chk("rst_start_ignored", 64'(busy), 64'd0);
    chk("rst_no_read", 64'(rd_total), 64'd0);

    // Single word at 0.
    base_addr = 32'd0; word_count = 16'd1; start = 1'b1; rd0 = rd_total;
    step(); start = 1'b0;
    chk("t1_rd_en", 64'(mem_rd_en), 64'd1);
    chk("t1_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    step();
    chk("t1_rd_en_off", 64'(mem_rd_en), 64'd0);
    chk("t1_valid_early", 64'(dump_valid), 64'd0);
    step();
    chk("t1_valid", 64'(dump_valid), 64'd1);
    chk("t1_data", 64'(dump_data), 64'h0002_0820);
    chk("t1_daddr", 64'(dump_addr), 64'd0);
    chk("t1_last", 64'(dump_last), 64'd1);
    step();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_valid_off", 64'(dump_valid), 64'd0);
    step();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_reads", 64'(rd_total - rd0), 64'd1);

    // Misaligned base, two words; start and inputs wiggled while busy.
    base_addr = 32'd22; word_count = 16'd2; start = 1'b1; rd0 = rd_total;
    step(); start = 1'b0;
    chk("t2_rd_addr0", 64'(mem_rd_addr), 64'd20);
    chk("t2_rd_en0", 64'(mem_rd_en), 64'd1);
    step();
    start = 1'b1; base_addr = 32'd0; word_count = 16'd5;
    step();
    chk("t2_data0", 64'(dump_data), 64'h2022_0008);
    chk("t2_daddr0", 64'(dump_addr), 64'd20);
    chk("t2_last0", 64'(dump_last), 64'd0);
    step();
    chk("t2_rd_en1", 64'(mem_rd_en), 64'd1);
    chk("t2_rd_addr1", 64'(mem_rd_addr), 64'd24);
    step(); step();
    start = 1'b0;
    chk("t2_valid1", 64'(dump_valid), 64'd1);
    chk("t2_data1", 64'(dump_data), 64'h1000_FFFF);
    chk("t2_daddr1", 64'(dump_addr), 64'd24);
    chk("t2_last1", 64'(dump_last), 64'd1);
    step();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_cksum", 64'(checksum), CK_EN ? 64'h3023_0007 : 64'd0);
    step();
    chk("t2_idle", 64'(busy), 64'd0);
    chk("t2_reads", 64'(rd_total - rd0), 64'd2);
    step();
    chk("t2_cksum_hold", 64'(checksum), CK_EN ? 64'h3023_0007 : 64'd0);

    // Backpressure: ready low for 10 cycles after the first valid.
    base_addr = 32'd12; word_count = 16'd2; dump_ready = 1'b0; start = 1'b1; rd0 = rd_total;
    step(); start = 1'b0;
    step(); step();
    chk("t3_valid", 64'(dump_valid), 64'd1);
    chk("t3_data", 64'(dump_data), 64'hAC09_000C);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_valid", 64'(dump_valid), 64'd1);
      chk("t3_hold_data", 64'(dump_data), 64'hAC09_000C);
      chk("t3_hold_rd_en", 64'(mem_rd_en), 64'd0);
    end
    chk("t3_single_read", 64'(rd_total - rd0), 64'd1);
    dump_ready = 1'b1;
    step();
    chk("t3_rd_en1", 64'(mem_rd_en), 64'd1);
    chk("t3_rd_addr1", 64'(mem_rd_addr), 64'd16);
    step(); step();
    chk("t3_data1", 64'(dump_data), 64'h8C0C_000C);
    chk("t3_last1", 64'(dump_last), 64'd1);
    step();
    chk("t3_done", 64'(done), 64'd1);
    step();

    // Zero-length request.
    base_addr = 32'd0; word_count = 16'd0; start = 1'b1; rd0 = rd_total;
    step(); start = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_rd_en", 64'(mem_rd_en), 64'd0);
    chk("t4_cksum", 64'(checksum), 64'd0);
    step();
    chk("t4_done_pulse", 64'(done), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_no_read", 64'(rd_total - rd0), 64'd0);

    // Address wrap at the top of the space.
    base_addr = 32'hFFFF_FFFC; word_count = 16'd2; start = 1'b1;
    step(); start = 1'b0;
    chk("t5_rd_addr0", 64'(mem_rd_addr), 64'hFFFF_FFFC);
    step(); step();
    chk("t5_daddr0", 64'(dump_addr), 64'hFFFF_FFFC);
    chk("t5_data0", 64'(dump_data), 64'h1234_5678);
    step();
    chk("t5_rd_addr1", 64'(mem_rd_addr), 64'd0);
    chk("t5_rd_en1", 64'(mem_rd_en), 64'd1);
    step(); step();
    chk("t5_daddr1", 64'(dump_addr), 64'd0);
    chk("t5_data1", 64'(dump_data), 64'h0002_0820);
    step();
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_cksum", 64'(checksum), CK_EN ? 64'h1236_5E98 : 64'd0);
    step();

    // Reset while presenting the first word of a 3-word dump, then a clean rerun.
    base_addr = 32'd12; word_count = 16'd3; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("t6_pre_valid", 64'(dump_valid), 64'd1);
    rst = 1'b0;
    step();
    chk_reset_vals("t6_rst");
    rst = 1'b1;
    step();
    chk("t6_idle", 64'(busy), 64'd0);
    start = 1'b1; rd0 = rd_total;
    step(); start = 1'b0;
    chk("t6_rd_addr0", 64'(mem_rd_addr), 64'd12);
    step(); step();
    chk("t6_data0", 64'(dump_data), 64'hAC09_000C);
    step(); step(); step();
    chk("t6_data1", 64'(dump_data), 64'h8C0C_000C);
    chk("t6_daddr1", 64'(dump_addr), 64'd16);
    step(); step(); step();
    chk("t6_data2", 64'(dump_data), 64'h2022_0008);
    chk("t6_last2", 64'(dump_last), 64'd1);
    step();
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_cksum", 64'(checksum), CK_EN ? 64'h5837_0020 : 64'd0);
    chk("t6_reads", 64'(rd_total - rd0), 64'd3);
    step();
    chk("t6_end_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
